// File: rtl/full_adder_half_adder.sv
// full_adder_half_adder: half adder leaf used twice inside full_adder.
//   x, y : operand bits
//   s    : sum bit, x ^ y
//   c    : carry bit, x & y
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder, {cout,sum} = a + b + cin, optionally registered.
//   a, b, cin : addend bits and carry in (b pre-XORed with sub by subtracting callers)
//   cout, sum : carry out and sum bit
//   clk       : clock, only used when REGISTER_OUT=1
//   rst_n     : synchronous active-low reset, only used when REGISTER_OUT=1
//   REGISTER_OUT : 0 = combinational, zero latency; 1 = registered, one-cycle latency
// Port order is fixed so positional ripple-chain instantiations keep binding.
module full_adder #(
    parameter int REGISTER_OUT = 0
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum,
    input  logic clk,
    input  logic rst_n
);
    logic s0, c0, s1, c1;
    half_adder u_ha_ab  (.x(a),  .y(b),   .s(s0), .c(c0));
    half_adder u_ha_cin (.x(s0), .y(cin), .s(s1), .c(c1));
    // The two half-adder carries are never both set, so OR gives the full carry.
    if (REGISTER_OUT == 0) begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};
        assign cout = c0 | c1;
        assign sum  = s1;
    end else if (REGISTER_OUT == 1) begin : g_reg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cout <= 1'b0;
                sum  <= 1'b0;
            end else begin
                cout <= c0 | c1;
                sum  <= s1;
            end
        end
    end else begin : g_bad
        $error("full_adder: REGISTER_OUT must be 0 or 1");
    end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: table-driven and scoreboard checks of full_adder in both modes and in ripple chains.
module tb_full_adder;
    typedef struct {logic [2:0] in; logic [1:0] exp;} fa_vec_t;
    typedef struct {logic [3:0] a; logic [3:0] b; logic [4:0] exp;} add4_t;
    typedef struct {logic [7:0] a; logic [7:0] b; logic sub; logic [8:0] exp;} add8_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic rst_n, a, b, cin, cout_c, sum_c;
    logic rst_n_r, ra, rb, rcin, cout_r, sum_r;
    logic [3:0] a4, b4, s4;
    logic [4:0] c4;
    logic [7:0] a8, b8, bx8, s8;
    logic [8:0] c8;
    logic sub;
    logic [1:0] sb[$];

    full_adder #(.REGISTER_OUT(0)) dut_comb (.a(a), .b(b), .cin(cin), .cout(cout_c), .sum(sum_c), .clk(clk), .rst_n(rst_n));
    full_adder #(.REGISTER_OUT(1)) dut_reg (.a(ra), .b(rb), .cin(rcin), .cout(cout_r), .sum(sum_r), .clk(clk), .rst_n(rst_n_r));

    assign c4[0] = 1'b0;
    for (genvar i = 0; i < 4; i++) begin : g_chain4
        full_adder #(.REGISTER_OUT(0)) u_fa (.a(a4[i]), .b(b4[i]), .cin(c4[i]), .cout(c4[i+1]), .sum(s4[i]), .clk(clk), .rst_n(rst_n));
    end

    assign bx8 = b8 ^ {8{sub}};
    assign c8[0] = sub;
    for (genvar i = 0; i < 8; i++) begin : g_chain8
        full_adder #(.REGISTER_OUT(0)) u_fa (.a(a8[i]), .b(bx8[i]), .cin(c8[i]), .cout(c8[i+1]), .sum(s8[i]), .clk(clk), .rst_n(rst_n));
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive the registered DUT at the falling edge; the result captured at the
    // preceding rising edge is compared against the oldest scoreboard entry.
    task automatic step(input logic na, input logic nb, input logic nci, input logic nrst, input logic [1:0] exp);
        @(negedge clk);
        if (sb.size() > 0) check("reg", {7'd0, cout_r, sum_r}, {7'd0, sb.pop_front()});
        ra = na;
        rb = nb;
        rcin = nci;
        rst_n_r = nrst;
        sb.push_back(exp);
    endtask

    fa_vec_t fa_tab[8];
    add4_t   add4_tab[3];
    add8_t   add8_tab[3];

    initial begin
        fa_tab[0] = '{3'b000, 2'b00};
        fa_tab[1] = '{3'b001, 2'b01};
        fa_tab[2] = '{3'b010, 2'b01};
        fa_tab[3] = '{3'b011, 2'b10};
        fa_tab[4] = '{3'b100, 2'b01};
        fa_tab[5] = '{3'b101, 2'b10};
        fa_tab[6] = '{3'b110, 2'b10};
        fa_tab[7] = '{3'b111, 2'b11};
        add4_tab[0] = '{4'b1101, 4'b1010, 5'b10111};
        add4_tab[1] = '{4'b1111, 4'b0001, 5'b10000};
        add4_tab[2] = '{4'b0101, 4'b1010, 5'b01111};
        add8_tab[0] = '{8'd245, 8'd3, 1'b0, {1'b0, 8'd248}};
        add8_tab[1] = '{8'd255, 8'd1, 1'b0, {1'b1, 8'd0}};
        add8_tab[2] = '{8'd15, 8'd33, 1'b1, {1'b0, 8'hEE}};
        rst_n = 1'b1;
        rst_n_r = 1'b0;
        ra = 1'b1;
        rb = 1'b1;
        rcin = 1'b1;
        a4 = '0;
        b4 = '0;
        a8 = '0;
        b8 = '0;
        sub = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {a, b, cin} = fa_tab[i].in;
            #1;
            check($sformatf("comb_%03b", fa_tab[i].in), {7'd0, cout_c, sum_c}, {7'd0, fa_tab[i].exp});
        end
        for (int i = 0; i < 3; i++) begin
            a4 = add4_tab[i].a;
            b4 = add4_tab[i].b;
            #1;
            check($sformatf("chain4_%0d", i), {4'd0, c4[4], s4}, {4'd0, add4_tab[i].exp});
        end
        for (int i = 0; i < 3; i++) begin
            a8 = add8_tab[i].a;
            b8 = add8_tab[i].b;
            sub = add8_tab[i].sub;
            #1;
            check($sformatf("chain8_%0d", i), {c8[8], s8}, add8_tab[i].exp);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        for (int i = 0; i < 20; i++) begin
            logic na, nb, nci;
            na = 1'($urandom_range(1));
            nb = 1'($urandom_range(1));
            nci = 1'($urandom_range(1));
            step(na, nb, nci, 1'b1, 2'({1'b0, na} + {1'b0, nb} + {1'b0, nci}));
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        @(negedge clk);
        check("reg_drain", {7'd0, cout_r, sum_r}, {7'd0, sb.pop_front()});
        check("sb_empty", 9'(sb.size()), 9'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
